alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Upstream stage of the alarm LED/buzzer drivers: compares running clock time against the stored alarm time.
- Runs the ring / snooze / dismiss state machine.
- Produces the registered `sound_alarm` level consumed by the LED driver and sound stages.
- Time base is the one-second tick from the timekeeping counter.

Parameters:
- RING_TIMEOUT, 60: seconds of continuous ringing before auto-dismiss.
- SNOOZE_SEC, 300: snooze interval in seconds.
- MAX_SNOOZE, 3: snooze limit; used only when ALARM_SNOOZE_LIMIT_EN is defined.
- TMR_W, 9: width of the ring/snooze second counter; must hold max(RING_TIMEOUT, SNOOZE_SEC).
- SNZ_W, 4: width of `snooze_count`.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sec_tick  input  1  one-cycle pulse per second.
- cur_hour  input  5  current hour, binary 0-23.
- cur_min  input  6  current minute, binary 0-59.
- alarm_hour  input  5  alarm hour, binary 0-23.
- alarm_min  input  6  alarm minute, binary 0-59.
- alarm_enable  input  1  level; alarm armed when 1.
- snooze_btn  input  1  one-cycle pulse, already debounced.
- stop_btn  input  1  one-cycle pulse, already debounced.
- sound_alarm  output  1  registered; 1 while ringing.
- snooze_active  output  1  registered; 1 while in SNOOZE.
- alarm_state  output  2  registered state encoding.
- snooze_count  output  SNZ_W  snoozes taken in the current alarm event.

Behaviour:
- Reset: clk and reset are as already decided (one clock, synchronous active-high reset). On reset, all outputs are 0, the state is IDLE and the timer is 0. Reset wins over every other input in the same cycle, including mid-ring and mid-snooze.
- match = (cur_hour == alarm_hour) && (cur_min == alarm_min). This is a level, true for the whole alarm minute.
- State encoding: IDLE=2'b00, RINGING=2'b01, SNOOZE=2'b10, HOLDOFF=2'b11.
- All outputs are registered. Each output changes one clk after the qualifying input cycle.
- Priority within a cycle: reset > alarm_enable low > stop_btn > snooze_btn > sec_tick.
- IDLE:
  - alarm_enable && match -> RINGING; timer=0, snooze_count=0.
  - Arming mid-minute while the time already matches triggers immediately.
- RINGING (sound_alarm=1):
  - alarm_enable=0 or stop_btn -> HOLDOFF.
  - snooze_btn (if permitted) -> SNOOZE; timer=SNOOZE_SEC, snooze_count+1, saturating at all-ones.
  - sec_tick -> timer+1. When the tick arrives with timer == RING_TIMEOUT-1 -> HOLDOFF (auto-dismiss).
- SNOOZE (sound_alarm=0, snooze_active=1):
  - alarm_enable=0 or stop_btn -> HOLDOFF.
  - snooze_btn ignored.
  - sec_tick -> timer-1. When the tick arrives with timer == 1 -> RINGING; timer=0.
- HOLDOFF (both flags 0):
  - Stays until match == 0, then -> IDLE.
  - Prevents retrigger within the same alarm minute after stop/timeout.
  - snooze_count is held until the next IDLE->RINGING.
- Simultaneous events:
  - stop_btn and snooze_btn in the same cycle: stop wins.
  - Button and sec_tick in the same cycle: the button action is taken and the tick is dropped for that cycle.
- Snooze expiry does not require match; re-ring is driven by the timer only.
- alarm_hour/alarm_min changes during RINGING or SNOOZE do not affect the current event.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ALARM_SNOOZE_LIMIT_EN.
- Defined: snooze_btn in RINGING is honoured only while snooze_count < MAX_SNOOZE. Once the limit is reached it is ignored and ringing continues to timeout or stop.
- Undefined: snooze is unlimited; snooze_count saturates at 2^SNZ_W-1 and has no other effect.

Test Plan (RING_TIMEOUT=5, SNOOZE_SEC=3, MAX_SNOOZE=2, one tick per 10 clk):
- alarm 07:30, enable=1, time steps 07:29 -> 07:30 -> sound_alarm=1 and alarm_state=01 one clk later. After 5 ticks -> state=11, sound_alarm=0. Time -> 07:31 -> state=00.
- Ringing, snooze_btn pulse -> snooze_active=1, snooze_count=1. After 3 ticks -> sound_alarm=1, state=01.
- Ringing, stop_btn and snooze_btn same cycle -> state=11, snooze_count unchanged. Re-ring does not occur while time still 07:30.
- SNOOZE, alarm_enable -> 0 -> state=11, all flags 0. reset asserted mid-ring -> all outputs 0 next clk.
- With ALARM_SNOOZE_LIMIT_EN: snooze twice, third snooze_btn -> stays RINGING with snooze_count=2. Without the macro, the third snooze is accepted and snooze_count=3.
- alarm_enable raised at 07:30:40 -> rings immediately. alarm_enable=0 at 07:30 -> never rings.

Source files
------------

// File: rtl/alarm_controller_if.sv
// Signal bundle between the timekeeping/button front end and the alarm controller.
// master drives time, alarm setting and buttons; slave (the controller) returns the alarm status.
interface alarm_controller_if #(
  parameter int SNZ_W = 4
);
  logic             sec_tick;
  logic [4:0]       cur_hour;
  logic [5:0]       cur_min;
  logic [4:0]       alarm_hour;
  logic [5:0]       alarm_min;
  logic             alarm_enable;
  logic             snooze_btn;
  logic             stop_btn;
  logic             sound_alarm;
  logic             snooze_active;
  logic [1:0]       alarm_state;
  logic [SNZ_W-1:0] snooze_count;

  modport master (
    output sec_tick, cur_hour, cur_min, alarm_hour, alarm_min,
           alarm_enable, snooze_btn, stop_btn,
    input  sound_alarm, snooze_active, alarm_state, snooze_count
  );

  modport slave (
    input  sec_tick, cur_hour, cur_min, alarm_hour, alarm_min,
           alarm_enable, snooze_btn, stop_btn,
    output sound_alarm, snooze_active, alarm_state, snooze_count
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm ring/snooze/dismiss controller driven by the one-second tick.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps the snoozes per alarm event at MAX_SNOOZE.
//
//   state   | meaning
//   IDLE    | armed or disarmed, waiting for the alarm minute
//   RINGING | sound_alarm high, counting seconds toward auto-dismiss
//   SNOOZE  | silenced, counting down to the next ring
//   HOLDOFF | event finished, waiting for the alarm minute to pass
module alarm_controller #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_SEC   = 300,
  parameter int MAX_SNOOZE   = 3,
  parameter int TMR_W        = 9,
  parameter int SNZ_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  alarm_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RINGING = 2'b01,
    S_SNOOZE  = 2'b10,
    S_HOLDOFF = 2'b11
  } state_t;

  // Elaboration guards against counters too narrow for the chosen parameters.
  if ((RING_TIMEOUT >= (1 << TMR_W)) || (SNOOZE_SEC >= (1 << TMR_W))) begin : g_tmr_chk
    $error("TMR_W too narrow for RING_TIMEOUT/SNOOZE_SEC");
  end
  if (MAX_SNOOZE >= (1 << SNZ_W)) begin : g_snz_chk
    $error("MAX_SNOOZE does not fit in snooze_count");
  end

  localparam logic [TMR_W-1:0] RING_LAST  = TMR_W'(RING_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SNOOZE_LD  = TMR_W'(SNOOZE_SEC);
  localparam logic [SNZ_W-1:0] SNZ_SAT    = '1;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             sound_q, sound_d;
  logic             snz_act_q, snz_act_d;
  logic             match;
  logic             snooze_ok;

  always_comb begin
    match = (bus.cur_hour == bus.alarm_hour) && (bus.cur_min == bus.alarm_min);
`ifdef ALARM_SNOOZE_LIMIT_EN
    snooze_ok = (snz_cnt_q < SNZ_W'(MAX_SNOOZE));
`else
    snooze_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    snz_cnt_d = snz_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.alarm_enable && match) begin
          state_d   = S_RINGING;
          timer_d   = '0;
          snz_cnt_d = '0;
        end
      end
      S_RINGING: begin
        // A button handled this cycle swallows any coincident tick.
        if (!bus.alarm_enable || bus.stop_btn) begin
          state_d = S_HOLDOFF;
        end else if (bus.snooze_btn && snooze_ok) begin
          state_d = S_SNOOZE;
          timer_d = SNOOZE_LD;
          if (snz_cnt_q != SNZ_SAT) snz_cnt_d = snz_cnt_q + 1'b1;
        end else if (bus.sec_tick) begin
          if (timer_q == RING_LAST) state_d = S_HOLDOFF;
          else                      timer_d = timer_q + 1'b1;
        end
      end
      S_SNOOZE: begin
        if (!bus.alarm_enable || bus.stop_btn) begin
          state_d = S_HOLDOFF;
        end else if (bus.sec_tick) begin
          if (timer_q == TMR_W'(1)) begin
            state_d = S_RINGING;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      S_HOLDOFF: begin
        if (!match) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    sound_d   = (state_d == S_RINGING);
    snz_act_d = (state_d == S_SNOOZE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      snz_cnt_q <= '0;
      sound_q   <= 1'b0;
      snz_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      snz_cnt_q <= snz_cnt_d;
      sound_q   <= sound_d;
      snz_act_q <= snz_act_d;
    end
  end

  assign bus.sound_alarm   = sound_q;
  assign bus.snooze_active = snz_act_q;
  assign bus.alarm_state   = state_q;
  assign bus.snooze_count  = snz_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a per-cycle behavioural model check.
// Expectations for the third snooze follow ALARM_SNOOZE_LIMIT_EN.
module tb_alarm_controller;
  localparam int RT  = 5;
  localparam int SS  = 3;
  localparam int MS  = 2;
  localparam int SZW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alarm_controller_if #(.SNZ_W(SZW)) bus();

  alarm_controller #(
    .RING_TIMEOUT(RT), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS), .TMR_W(9), .SNZ_W(SZW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: the alarm event as a set of flags plus elapsed/remaining seconds.
  bit m_ring, m_snz, m_hold;
  int m_rung, m_left, m_snoozes;

  function automatic int m_state();
    if (m_ring) return 1;
    if (m_snz)  return 2;
    if (m_hold) return 3;
    return 0;
  endfunction

  function automatic bit snooze_allowed(int taken);
`ifdef ALARM_SNOOZE_LIMIT_EN
    return taken < MS;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    bit same_minute;
    same_minute = (bus.cur_hour == bus.alarm_hour) && (bus.cur_min == bus.alarm_min);
    if (reset) begin
      m_ring = 0; m_snz = 0; m_hold = 0; m_rung = 0; m_left = 0; m_snoozes = 0;
    end else if (m_ring) begin
      if (!bus.alarm_enable || bus.stop_btn) begin
        m_ring = 0; m_hold = 1;
      end else if (bus.snooze_btn && snooze_allowed(m_snoozes)) begin
        m_ring = 0; m_snz = 1; m_left = SS;
        m_snoozes = (m_snoozes + 1 > (1 << SZW) - 1) ? (1 << SZW) - 1 : m_snoozes + 1;
      end else if (bus.sec_tick) begin
        m_rung++;
        if (m_rung >= RT) begin m_ring = 0; m_hold = 1; end
      end
    end else if (m_snz) begin
      if (!bus.alarm_enable || bus.stop_btn) begin
        m_snz = 0; m_hold = 1;
      end else if (bus.sec_tick) begin
        m_left--;
        if (m_left == 0) begin m_snz = 0; m_ring = 1; m_rung = 0; end
      end
    end else if (m_hold) begin
      if (!same_minute) m_hold = 0;
    end else if (bus.alarm_enable && same_minute) begin
      m_ring = 1; m_rung = 0; m_snoozes = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state",         int'(bus.alarm_state),   m_state());
      chk("sound_alarm",   int'(bus.sound_alarm),   int'(m_ring));
      chk("snooze_active", int'(bus.snooze_active), int'(m_snz));
      chk("snooze_count",  int'(bus.snooze_count),  m_snoozes);
    end
  end

  int cyc = 0;
  bit tick_on = 0;
  bit pend_stop = 0, pend_snz = 0;

  task automatic adv(int n);
    repeat (n) begin
      @(negedge clk);
      bus.sec_tick   = tick_on && (cyc % 10 == 9);
      bus.stop_btn   = pend_stop;
      bus.snooze_btn = pend_snz;
      pend_stop = 0;
      pend_snz  = 0;
      cyc++;
    end
  endtask

  task automatic press(bit stp, bit snz);
    pend_stop = stp;
    pend_snz  = snz;
    adv(1);
  endtask

  initial begin
    bus.sec_tick = 0; bus.stop_btn = 0; bus.snooze_btn = 0;
    bus.cur_hour = 5'd7; bus.cur_min = 6'd29;
    bus.alarm_hour = 5'd7; bus.alarm_min = 6'd30;
    bus.alarm_enable = 1;
    adv(3);
    cmp_en = 1;
    chk("rst_state", int'(bus.alarm_state), 0);
    chk("rst_sound", int'(bus.sound_alarm), 0);
    reset = 0;
    tick_on = 1;

    // Minute rollover into the alarm time, ring, auto-dismiss, release.
    adv(5);
    chk("pre_match_state", int'(bus.alarm_state), 0);
    bus.cur_min = 6'd30;
    adv(1);
    chk("ring_state", int'(bus.alarm_state), 1);
    chk("ring_sound", int'(bus.sound_alarm), 1);
    adv(60);
    chk("timeout_state", int'(bus.alarm_state), 3);
    chk("timeout_sound", int'(bus.sound_alarm), 0);
    bus.cur_min = 6'd31;
    adv(2);
    chk("release_state", int'(bus.alarm_state), 0);

    // Snooze and re-ring, then stop+snooze together.
    bus.alarm_min = 6'd32; bus.cur_min = 6'd32;
    adv(2);
    press(0, 1);
    adv(1);
    chk("snz_active", int'(bus.snooze_active), 1);
    chk("snz_count1", int'(bus.snooze_count), 1);
    adv(40);
    chk("rering_state", int'(bus.alarm_state), 1);
    chk("rering_sound", int'(bus.sound_alarm), 1);
    press(1, 1);
    adv(1);
    chk("stop_wins_state", int'(bus.alarm_state), 3);
    chk("stop_wins_count", int'(bus.snooze_count), 1);
    adv(30);
    chk("no_retrigger", int'(bus.alarm_state), 3);

    // Disarm during snooze, then reset mid-ring.
    bus.cur_min = 6'd33;
    adv(2);
    bus.alarm_min = 6'd33;
    adv(2);
    press(0, 1);
    adv(1);
    bus.alarm_enable = 0;
    adv(1);
    chk("disarm_state", int'(bus.alarm_state), 3);
    chk("disarm_snz", int'(bus.snooze_active), 0);
    bus.alarm_enable = 1;
    bus.cur_min = 6'd34;
    adv(2);
    bus.alarm_min = 6'd34;
    adv(2);
    press(0, 1);
    adv(40);
    reset = 1;
    adv(1);
    chk("rst_mid_state", int'(bus.alarm_state), 0);
    chk("rst_mid_sound", int'(bus.sound_alarm), 0);
    chk("rst_mid_count", int'(bus.snooze_count), 0);
    adv(1);
    reset = 0;

    // Snooze limit: third request.
    adv(2);
    press(0, 1);
    adv(40);
    press(0, 1);
    adv(40);
    chk("second_rering", int'(bus.alarm_state), 1);
    press(0, 1);
    adv(1);
`ifdef ALARM_SNOOZE_LIMIT_EN
    chk("third_snz_state", int'(bus.alarm_state), 1);
    chk("third_snz_count", int'(bus.snooze_count), 2);
`else
    chk("third_snz_state", int'(bus.alarm_state), 2);
    chk("third_snz_count", int'(bus.snooze_count), 3);
`endif
    adv(5);
    press(1, 0);
    adv(2);

    // Arming mid-minute rings at once; disarmed minute never rings.
    bus.cur_min = 6'd39;
    adv(2);
    bus.alarm_enable = 0;
    bus.alarm_min = 6'd40; bus.cur_min = 6'd40;
    adv(20);
    chk("disarmed_idle", int'(bus.alarm_state), 0);
    bus.alarm_enable = 1;
    adv(1);
    chk("late_arm_ring", int'(bus.sound_alarm), 1);
    bus.alarm_enable = 0;
    adv(1);
    bus.cur_min = 6'd41;
    adv(2);
    bus.alarm_min = 6'd42; bus.cur_min = 6'd42;
    adv(30);
    chk("never_ring_state", int'(bus.alarm_state), 0);
    chk("never_ring_sound", int'(bus.sound_alarm), 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
